// File: rtl/riscv_pkg.sv
// Shared branch funct3 codes and the PC sequencer state type.
package riscv_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } pc_state_t;
endpackage

// File: rtl/pc_next_unit_branch_cond.sv
// RV32I branch condition evaluation from ALU comparison flags.
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       cond_o
);

  always_comb begin
    cond_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond_o = zero_i;
      F3_BNE:  cond_o = ~zero_i;
      F3_BLT:  cond_o = lt_i;
      F3_BGE:  cond_o = ~lt_i;
      F3_BLTU: cond_o = ltu_i;
      F3_BGEU: cond_o = ~ltu_i;
      default: cond_o = 1'b0; // 010/011 are reserved encodings
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// Registered program counter with next-PC selection, misaligned-target trap
// handling and a saturating count of committed control transfers.
module pc_next_unit
  import riscv_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100,
  parameter int               IALIGN       = 32,
  parameter int               CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic             jump,
  input  logic             jalr,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic [XLEN-1:0]  pc_imm_target,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             trap_ack,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             taken,
  output logic             misaligned,
  output logic [CNT_W-1:0] taken_count,
  output pc_state_t        state_dbg_o
);

  pc_state_t        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cond;
  logic [XLEN-1:0]  target;
  logic             target_bad;

  branch_cond u_branch_cond (
    .funct3_i (funct3),
    .zero_i   (zero),
    .lt_i     (lt),
    .ltu_i    (ltu),
    .cond_o   (cond)
  );

  // JALR clears the target LSB; jalr has priority over jump and branch.
  assign target     = jalr ? (alu_result & ~XLEN'(1)) : pc_imm_target;
  assign target_bad = (IALIGN == 32) ? target[1] : target[0];
  assign pc_plus4   = pc_q + XLEN'(4);
  assign taken      = (state_q == RUN) & (jalr | jump | (branch & cond));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (!stall && taken && target_bad) state_d = TRAP;
      TRAP:    if (trap_ack) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    mis_d = mis_q;
    cnt_d = cnt_q;
    case (state_q)
      RUN: begin
        if (!stall) begin
          if (taken && target_bad) begin
            mis_d = 1'b1;
          end else if (taken) begin
            pc_d  = target;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      TRAP: begin
        // Acknowledge wins over stall so a stalled pipeline can still vector.
        if (trap_ack) begin
          pc_d  = TRAP_VECTOR;
          mis_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign pc          = pc_q;
  assign misaligned  = mis_q;
  assign taken_count = cnt_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: a spec-level PC model checked every cycle
// plus literal expectations; a CNT_W=2 instance shares the stimulus.
module tb_pc_next_unit;
  import riscv_pkg::*;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b1;

  logic        stall, branch, jump, jalr, zero, lt, ltu, trap_ack;
  logic [2:0]  funct3;
  logic [31:0] pc_imm_target, alu_result;

  logic [31:0] pc, pc_plus4, pc_s, pc_plus4_s;
  logic        taken, misaligned, taken_s, mis_s;
  logic [15:0] taken_count;
  logic [1:0]  cnt_s;
  pc_state_t   state, state_s;

  pc_next_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .branch(branch), .jump(jump),
    .jalr(jalr), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .pc_imm_target(pc_imm_target), .alu_result(alu_result), .trap_ack(trap_ack),
    .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .misaligned(misaligned),
    .taken_count(taken_count), .state_dbg_o(state)
  );

  pc_next_unit #(.CNT_W(2)) dut_small (
    .clock(clock), .reset(reset), .stall(stall), .branch(branch), .jump(jump),
    .jalr(jalr), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .pc_imm_target(pc_imm_target), .alu_result(alu_result), .trap_ack(trap_ack),
    .pc(pc_s), .pc_plus4(pc_plus4_s), .taken(taken_s), .misaligned(mis_s),
    .taken_count(cnt_s), .state_dbg_o(state_s)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // behavioural model
  logic [31:0] m_pc;
  bit          m_trap;
  int          m_cnt16, m_cnt2;

  function automatic bit m_cond();
    case (funct3)
      3'd0:    return zero;
      3'd1:    return !zero;
      3'd4:    return lt;
      3'd5:    return !lt;
      3'd6:    return ltu;
      3'd7:    return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_taken();
    return !m_trap && (jalr || jump || (branch && m_cond()));
  endfunction

  function automatic logic [31:0] m_target();
    return jalr ? (alu_result & 32'hFFFF_FFFE) : pc_imm_target;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_pc = 32'h0; m_trap = 1'b0; m_cnt16 = 0; m_cnt2 = 0;
    end else if (m_trap) begin
      if (trap_ack) begin
        m_pc = 32'h100; m_trap = 1'b0;
      end
    end else if (!stall) begin
      if (m_taken()) begin
        if ((m_target() % 4) != 0) m_trap = 1'b1;
        else begin
          m_pc    = m_target();
          m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
          m_cnt2  = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // compare process
  always @(negedge clock) begin
    if (cmp_en) begin
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("taken", {31'b0, taken}, {31'b0, m_taken()});
      check("misaligned", {31'b0, misaligned}, {31'b0, m_trap});
      check("taken_count", {16'b0, taken_count}, m_cnt16);
      check("state", {31'b0, state}, {31'b0, m_trap});
      check("pc_small", pc_s, m_pc);
      check("taken_small", {31'b0, taken_s}, {31'b0, m_taken()});
      check("count_small", {30'b0, cnt_s}, m_cnt2);
    end
  end

  // driver tasks
  task automatic set_in(input bit b, input bit j, input bit jr, input logic [2:0] f3,
                        input bit z, input bit l, input bit lu,
                        input logic [31:0] tgt, input logic [31:0] alu,
                        input bit ack, input bit st);
    branch = b; jump = j; jalr = jr; funct3 = f3; zero = z; lt = l; ltu = lu;
    pc_imm_target = tgt; alu_result = alu; trap_ack = ack; stall = st;
  endtask

  task automatic drive(input bit b, input bit j, input bit jr, input logic [2:0] f3,
                       input bit z, input bit l, input bit lu,
                       input logic [31:0] tgt, input logic [31:0] alu,
                       input bit ack, input bit st);
    set_in(b, j, jr, f3, z, l, lu, tgt, alu, ack, st);
    @(posedge clock); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  initial begin
    set_in(0, 0, 0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    cmp_en = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("lit_reset_pc", pc, 32'h0);
    check("lit_reset_cnt", {16'b0, taken_count}, 32'd0);
    check("lit_reset_mis", {31'b0, misaligned}, 32'd0);

    for (int i = 1; i <= 3; i++) begin
      idle();
      check("lit_idle_pc", pc, 32'(4 * i));
    end
    for (int i = 4; i <= 16; i++) idle();
    check("lit_pc_40", pc, 32'h40);

    drive(1, 0, 0, 3'b000, 1, 0, 0, 32'h80, 32'h0, 0, 0);
    check("lit_beq_taken", pc, 32'h80);
    check("lit_beq_cnt", {16'b0, taken_count}, 32'd1);
    drive(0, 1, 0, 3'b000, 0, 0, 0, 32'h40, 32'h0, 0, 0);
    drive(1, 0, 0, 3'b000, 0, 0, 0, 32'h80, 32'h0, 0, 0);
    check("lit_beq_not", pc, 32'h44);

    drive(1, 0, 0, 3'b101, 0, 1, 0, 32'h200, 32'h0, 0, 0);
    check("lit_bge_lt", pc, 32'h48);
    drive(1, 0, 0, 3'b110, 0, 0, 1, 32'h200, 32'h0, 0, 0);
    check("lit_bltu", pc, 32'h200);
    drive(1, 0, 0, 3'b010, 1, 1, 1, 32'h300, 32'h0, 0, 0);
    check("lit_f3_010", pc, 32'h204);
    drive(1, 0, 0, 3'b011, 1, 1, 1, 32'h300, 32'h0, 0, 0);
    check("lit_f3_011", pc, 32'h208);
    drive(1, 0, 0, 3'b001, 0, 0, 0, 32'h400, 32'h0, 0, 0);
    drive(1, 0, 0, 3'b100, 0, 1, 0, 32'h500, 32'h0, 0, 0);
    drive(1, 0, 0, 3'b111, 0, 0, 0, 32'h600, 32'h0, 0, 0);
    check("lit_bgeu", pc, 32'h600);
    check("lit_cnt_6", {16'b0, taken_count}, 32'd6);
    drive(0, 0, 0, 3'b000, 1, 0, 0, 32'h700, 32'h0, 0, 0);
    check("lit_no_branch", pc, 32'h604);

    drive(1, 1, 1, 3'b000, 1, 0, 0, 32'h300, 32'h201, 0, 0);
    check("lit_jalr_prio", pc, 32'h200);

    set_in(0, 1, 0, 3'd0, 0, 0, 0, 32'h82, 32'h0, 0, 0);
    #1;
    check("lit_mis_taken", {31'b0, taken}, 32'd1);
    @(posedge clock); #1;
    check("lit_mis_pc", pc, 32'h200);
    check("lit_mis_flag", {31'b0, misaligned}, 32'd1);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 3'd0, 0, 0, 0, 32'h80, 32'h0, 0, 0);
    check("lit_trap_hold", pc, 32'h200);
    check("lit_trap_cnt", {16'b0, taken_count}, 32'd7);
    drive(0, 0, 0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 1, 1);
    check("lit_ack_pc", pc, 32'h100);
    check("lit_ack_mis", {31'b0, misaligned}, 32'd0);
    check("lit_ack_state", {31'b0, state}, 32'd0);
    drive(0, 0, 0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
    check("lit_ack_in_run", pc, 32'h104);

    drive(0, 0, 1, 3'd0, 0, 0, 0, 32'h0, 32'h203, 0, 0);
    check("lit_jalr_mis", {31'b0, misaligned}, 32'd1);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("lit_rst_trap_pc", pc, 32'h0);
    check("lit_rst_trap_mis", {31'b0, misaligned}, 32'd0);

    for (int i = 1; i <= 5; i++) drive(0, 1, 0, 3'd0, 0, 0, 0, 32'(16 * i), 32'h0, 0, 0);
    check("lit_5jumps_pc", pc, 32'h50);
    check("lit_5jumps_cnt", {16'b0, taken_count}, 32'd5);
    check("lit_sat_cnt2", {30'b0, cnt_s}, 32'd3);

    drive(0, 1, 0, 3'd0, 0, 0, 0, 32'h800, 32'h0, 0, 1);
    drive(0, 1, 0, 3'd0, 0, 0, 0, 32'h800, 32'h0, 0, 1);
    check("lit_stall_pc", pc, 32'h50);
    check("lit_stall_cnt", {16'b0, taken_count}, 32'd5);
    idle();
    check("lit_after_stall", pc, 32'h54);

    drive(0, 1, 0, 3'd0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 0);
    check("lit_plus4_wrap", pc_plus4, 32'h0);
    idle();
    check("lit_pc_wrap", pc, 32'h0);
    idle();
    idle();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
